// File: rtl/down_count_monitor_if.sv
// Bus between a 3-bit down counter and its checker: the monitored count
// plus the monitor's status outputs.
interface down_count_monitor_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WRAP_W = 8
);
    logic [WIDTH-1:0]  count_in;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              seq_err;

    // Counter / bench side: drives the count, observes the status
    modport master (
        output count_in,
        input  locked,
        input  wrap_pulse,
        input  wrap_cnt,
        input  seq_err
    );

    // Monitor side: consumes the count, drives the status
    modport slave (
        input  count_in,
        output locked,
        output wrap_pulse,
        output wrap_cnt,
        output seq_err
    );
endinterface

// File: rtl/down_count_monitor.sv
// down_count_monitor: checks that a down counter steps by exactly -1 each
// clock, pulses on every 0 -> all-ones wrap, keeps a saturating wrap count
// and latches a sticky error on any illegal step.
// Optional feature macro: MON_HOLD_EN (count_in == prev in TRACK is a legal
// stall instead of an error).
module down_count_monitor #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned WRAP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    down_count_monitor_if.slave  mon
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               locked_q, locked_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic               seq_err_q, seq_err_d;
    logic [WIDTH-1:0]   exp_c;

    // State and output registers; reset overrides every other event
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            locked_q     <= locked_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            seq_err_q    <= seq_err_d;
        end
    end

    // Next-state logic: capture reference, then check each step
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        locked_d     = locked_q;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        seq_err_d    = seq_err_q;
        exp_c        = prev_q - WIDTH'(1);

        case (state_q)
            IDLE: begin
                // First sample is the reference, whatever its value
                prev_d   = mon.count_in;
                locked_d = 1'b1;
                state_d  = TRACK;
            end
            TRACK: begin
                if (mon.count_in == prev_q) begin
`ifdef MON_HOLD_EN
                    // Counter stalled: accepted, nothing changes
                    prev_d = prev_q;
`else
                    seq_err_d = 1'b1;
                    state_d   = ERROR;
`endif
                end else if (mon.count_in == exp_c) begin
                    prev_d = mon.count_in;
                    if (prev_q == '0) begin
                        wrap_pulse_d = 1'b1;
                        if (wrap_cnt_q != WRAP_MAX) begin
                            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                        end
                    end
                end else begin
                    seq_err_d = 1'b1;
                    state_d   = ERROR;
                end
            end
            ERROR: begin
                // Sticky until reset; prev and wrap_cnt frozen
                seq_err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mon.locked     = locked_q;
    assign mon.wrap_pulse = wrap_pulse_q;
    assign mon.wrap_cnt   = wrap_cnt_q;
    assign mon.seq_err    = seq_err_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: two instances (WRAP_W=8 and WRAP_W=2) see
// the same count stream; directed scenarios plus random traffic are compared
// against a behavioural reference model.
module tb_down_count_monitor;

    localparam int unsigned WIDTH  = 3;
    localparam int unsigned WRAP_A = 8;
    localparam int unsigned WRAP_B = 2;
    localparam int MOD     = 1 << WIDTH;
    localparam int MAX_A   = (1 << WRAP_A) - 1;
    localparam int MAX_B   = (1 << WRAP_B) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] cur;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit m_locked;
    bit m_err;
    bit m_pulse;
    int m_ref;
    int m_wraps;

    always #5 clk = ~clk;

    down_count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_A)) ifa ();
    down_count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_B)) ifb ();

    assign ifa.count_in = cur;
    assign ifb.count_in = cur;

    down_count_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .mon (ifa)
    );

    down_count_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .mon (ifb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Behavioural model: one edge with the given reset and sample
    task automatic model_step(input bit r, input int c);
        m_pulse = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_err    = 1'b0;
            m_wraps  = 0;
            m_ref    = 0;
        end else if (!m_locked) begin
            m_locked = 1'b1;
            m_ref    = c;
        end else if (m_err) begin
            m_pulse = 1'b0;
        end else if (c == m_ref) begin
`ifndef MON_HOLD_EN
            m_err = 1'b1;
`endif
        end else if (c == (m_ref - 1 + MOD) % MOD) begin
            if (m_ref == 0) begin
                m_pulse = 1'b1;
                m_wraps++;
            end
            m_ref = c;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_model();
        check("locked_a", 32'(ifa.locked), 32'(m_locked));
        check("pulse_a", 32'(ifa.wrap_pulse), 32'(m_pulse));
        check("wcnt_a", 32'(ifa.wrap_cnt), 32'((m_wraps > MAX_A) ? MAX_A : m_wraps));
        check("err_a", 32'(ifa.seq_err), 32'(m_err));
        check("pulse_b", 32'(ifb.wrap_pulse), 32'(m_pulse));
        check("wcnt_b", 32'(ifb.wrap_cnt), 32'((m_wraps > MAX_B) ? MAX_B : m_wraps));
    endtask

    // One clock edge: update model with pre-edge inputs, sample after edge
    task automatic tick();
        @(posedge clk);
        model_step(rst, int'(cur));
        #1;
        check_model();
    endtask

    // Emulate the live down counter for n edges
    task automatic run_live(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cur = rst ? '0 : cur - WIDTH'(1);
        end
    endtask

    task automatic drive(input int v);
        cur = WIDTH'(v);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cur = '0;

        // Normal run: reset 10 cycles, then 40 cycles of live counter
        repeat (10) tick();
        check("rst_locked", 32'(ifa.locked), 32'd0);
        check("rst_wcnt", 32'(ifa.wrap_cnt), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check($sformatf("norm_lock_%0d", k), 32'(ifa.locked), 32'd1);
            check($sformatf("norm_pulse_%0d", k), 32'(ifa.wrap_pulse),
                  32'((k >= 2 && (k - 2) % 8 == 0) ? 1 : 0));
            cur = cur - WIDTH'(1);
        end
        check("norm_wcnt", 32'(ifa.wrap_cnt), 32'd5);
        check("norm_err", 32'(ifa.seq_err), 32'd0);
        check("sat_wcnt5", 32'(ifb.wrap_cnt), 32'd3);
        // Sixth wrap on the saturated counter still pulses
        for (int k = 41; k <= 48; k++) begin
            tick();
            check($sformatf("sat_pulse_%0d", k), 32'(ifb.wrap_pulse),
                  32'((k == 42) ? 1 : 0));
            cur = cur - WIDTH'(1);
        end
        check("sat_wcnt6", 32'(ifb.wrap_cnt), 32'd3);
        check("wcnt6_a", 32'(ifa.wrap_cnt), 32'd6);

        // Skip step: 6 (lock), 5, 4, 2 -> error; then stays in error
        rst = 1'b1; tick(); rst = 1'b0;
        drive(6); drive(5); drive(4);
        check("skip_pre", 32'(ifa.seq_err), 32'd0);
        drive(2);
        check("skip_err", 32'(ifa.seq_err), 32'd1);
        drive(1); drive(0);
        drive(7);
        check("skip_nopulse", 32'(ifa.wrap_pulse), 32'd0);
        check("skip_wcnt", 32'(ifa.wrap_cnt), 32'd0);
        check("skip_sticky", 32'(ifa.seq_err), 32'd1);
        check("skip_locked", 32'(ifa.locked), 32'd1);

        // Hold: 7 (lock), 6, 6
        rst = 1'b1; tick(); rst = 1'b0;
        drive(7); drive(6); drive(6);
`ifdef MON_HOLD_EN
        check("hold_ok", 32'(ifa.seq_err), 32'd0);
        drive(5);
        check("hold_then5", 32'(ifa.seq_err), 32'd0);
`else
        check("hold_err", 32'(ifa.seq_err), 32'd1);
`endif

        // Reset mid-operation: 3 wraps, force error, then 1-cycle reset
        rst = 1'b1; tick(); rst = 1'b0;
        cur = '0;
        run_live(18);
        check("mid_wcnt3", 32'(ifa.wrap_cnt), 32'd3);
        drive(3);
        check("mid_err", 32'(ifa.seq_err), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_err", 32'(ifa.seq_err), 32'd0);
        check("mid_rst_wcnt", 32'(ifa.wrap_cnt), 32'd0);
        check("mid_rst_locked", 32'(ifa.locked), 32'd0);
        drive(5);
        check("mid_relock", 32'(ifa.locked), 32'd1);

        // Reset coincident with the 0 -> 7 sample
        rst = 1'b1; tick(); rst = 1'b0;
        drive(2); drive(1); drive(0);
        rst = 1'b1;
        drive(7);
        check("coinc_pulse", 32'(ifa.wrap_pulse), 32'd0);
        check("coinc_wcnt", 32'(ifa.wrap_cnt), 32'd0);
        rst = 1'b0;

        // Random traffic: mostly legal steps with holds, jumps and resets
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst = (r < 3);
            if (r < 10)      cur = WIDTH'($urandom);
            else if (r < 16) cur = cur;
            else             cur = cur - WIDTH'(1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
